// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
`timescale 1ns/1ps
package fifo_arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_e;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_MAX_BURST = 4;

  localparam logic [15:0] STALL_MAX = 16'hFFFF;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req after index last, wrapping.
`timescale 1ns/1ps
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] grant,
  output logic          any_req
);
  int idx;

  // Walk from farthest to nearest so the nearest candidate after last overwrites.
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last) + k) % N;
      if (req[idx]) begin
        grant   = IW'(idx);
        any_req = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ requesters,
// with zero-latency data path and a saturating back-pressure stall counter.
`timescale 1ns/1ps
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       full,
  output logic                       Wr_enable,
  output logic [DATA_W-1:0]          data_in,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic [15:0]                stall_cycles
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_e    state;
  logic [IW-1:0] last_grant;
  logic [IW-1:0] pick;
  logic          any_req;
  logic [BW-1:0] beat_cnt;
  logic          g_valid;
  logic          g_last;
  logic          xfer;
  logic          burst_end;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req     (req_valid),
    .last    (last_grant),
    .grant   (pick),
    .any_req (any_req)
  );

  assign busy = (state == ARB_BURST);

  // Outputs are purely combinational from state so an async reset clears them at once.
  always_comb begin
    g_valid   = req_valid[grant_id];
    g_last    = req_last[grant_id];
    xfer      = busy && g_valid && !full;
    Wr_enable = xfer;
    req_ready = '0;
    if (busy) req_ready[grant_id] = !full;
    data_in   = busy ? req_data[int'(grant_id)*DATA_W +: DATA_W] : '0;
    burst_end = busy && (!g_valid ||
                (xfer && (g_last || beat_cnt == BW'(MAX_BURST - 1))));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ARB_IDLE;
      last_grant   <= IW'(NUM_REQ - 1);
      beat_cnt     <= '0;
      grant_id     <= '0;
      stall_cycles <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (any_req) begin
            grant_id <= pick;
            beat_cnt <= '0;
            state    <= ARB_BURST;
          end
        end
        ARB_BURST: begin
          if (xfer) beat_cnt <= beat_cnt + BW'(1);
          if (g_valid && full && stall_cycles != STALL_MAX)
            stall_cycles <= stall_cycles + 16'd1;
          if (burst_end) begin
            state      <= ARB_IDLE;
            last_grant <= grant_id;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter; expected writes are queued by the stimulus
// and matched by a negedge monitor against grant_id, data_in and inter-write gap.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic            full;
  logic            Wr_enable;
  logic [DW-1:0]   data_in;
  logic [1:0]      grant_id;
  logic            busy;
  logic [15:0]     stall_cycles;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .full         (full),
    .Wr_enable    (Wr_enable),
    .data_in      (data_in),
    .grant_id     (grant_id),
    .busy         (busy),
    .stall_cycles (stall_cycles)
  );

  typedef struct {
    int          id;
    logic [31:0] data;
    int          gap;   // cycles since previous write; 0 = don't care
  } exp_t;

  exp_t         exp_q[$];
  exp_t         e_m;
  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;
  int           last_wr = 0;
  int           left[N];
  int           cnt[N];
  bit           last_en[N];
  logic [N-1:0] acc;

  function automatic logic [31:0] word(int i, int k);
    return {8'(i), 24'(k)};
  endfunction

  task automatic push(int i, int k, int gap);
    exp_q.push_back('{i, word(i, k), gap});
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]         = (left[i] > 0);
      req_last[i]          = last_en[i] && (left[i] == 1);
      req_data[i*DW +: DW] = word(i, cnt[i]);
    end
  endtask

  // One clock: sample handshakes mid-cycle, advance requesters just after the edge.
  task automatic tick();
    @(negedge clk);
    acc = req_ready & req_valid;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (acc[i]) begin
        cnt[i]++;
        left[i]--;
      end
    drive();
  endtask

  task automatic drain(int budget, string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_drain"}, 32'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    cyc++;
    if (Wr_enable === 1'b1) begin
      chk("wr_while_full", 32'(full), 0);
      if (exp_q.size() == 0) chk("unexpected_write", 32'(exp_q.size()), 1);
      else begin
        e_m = exp_q.pop_front();
        chk("grant_id", 32'(grant_id), e_m.id);
        chk("data_in", data_in, e_m.data);
        if (e_m.gap != 0) chk("write_gap", cyc - last_wr, e_m.gap);
      end
      last_wr = cyc;
    end
  end

  initial begin
    full = 1'b0;
    for (int i = 0; i < N; i++) begin
      left[i] = 0; cnt[i] = 0; last_en[i] = 1'b0;
    end
    drive();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_we", 32'(Wr_enable), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_data", data_in, 0);
    chk("rst_gid", 32'(grant_id), 0);
    chk("rst_stall", 32'(stall_cycles), 0);

    // Idle with no requests
    reset = 1'b1;
    repeat (5) begin
      tick();
      chk("idle_busy", 32'(busy), 0);
      chk("idle_ready", 32'(req_ready), 0);
    end
    chk("idle_stall", 32'(stall_cycles), 0);

    // All four requesting: bursts of 4 with one bubble, order 0,1,2,3,0
    for (int i = 0; i < N; i++) left[i] = 4;
    left[0] = 8;
    for (int b = 0; b < 5; b++)
      for (int k = 0; k < MB; k++)
        push(b % N, (b == 4 ? 4 : 0) + k, k > 0 ? 1 : (b == 0 ? 0 : 2));
    drive();
    drain(60, "rr");
    chk("rr_end_busy", 32'(busy), 0);

    // Requester 2 alone, 2 words ending with req_last
    left[2] = 2; last_en[2] = 1'b1;
    push(2, 4, 0); push(2, 5, 1);
    drive();
    drain(20, "last");
    chk("last_idle", 32'(busy), 0);

    // Requester 1: 6 words, full for 3 cycles after the first beat
    left[1] = 6;
    push(1, 4, 2); push(1, 5, 4); push(1, 6, 1); push(1, 7, 1);
    push(1, 8, 2); push(1, 9, 1);
    drive();
    tick();
    tick();
    full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("full_we", 32'(Wr_enable), 0);
      chk("full_ready", 32'(req_ready), 0);
      chk("full_busy", 32'(busy), 1);
      tick();
    end
    full = 1'b0;
    chk("stall3", 32'(stall_cycles), 3);
    drain(30, "full");
    repeat (2) tick();

    // Long full stall saturates the counter
    left[0] = 5; full = 1'b1;
    drive();
    tick();
    repeat (70000) tick();
    chk("stall_sat", 32'(stall_cycles), 32'hFFFF);
    tick();
    chk("stall_nowrap", 32'(stall_cycles), 32'hFFFF);
    chk("sat_we", 32'(Wr_enable), 0);
    full = 1'b0;
    push(0, 8, 0); push(0, 9, 1); push(0, 10, 1); push(0, 11, 1); push(0, 12, 2);
    drain(20, "sat");
    repeat (2) tick();

    // Reset during beat 2 of a requester-3 burst
    left[3] = 4;
    push(3, 4, 0);
    drive();
    tick();
    tick();
    chk("pre_rst_we", 32'(Wr_enable), 1);
    chk("pre_rst_gid", 32'(grant_id), 3);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_we", 32'(Wr_enable), 0);
    chk("mid_rst_ready", 32'(req_ready), 0);
    chk("mid_rst_data", data_in, 0);
    chk("mid_rst_gid", 32'(grant_id), 0);
    chk("mid_rst_stall", 32'(stall_cycles), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    left[0] = 1; last_en[0] = 1'b1;
    push(0, 13, 0); push(3, 5, 2); push(3, 6, 1); push(3, 7, 1);
    drive();
    tick();
    chk("post_rst_gid", 32'(grant_id), 0);
    chk("post_rst_busy", 32'(busy), 1);
    drain(30, "post_rst");
    repeat (3) tick();
    chk("final_busy", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

- Round-robin write-port arbiter that shares the single 32-bit FIFO write port between NUM_REQ requesters.
- Sequences each grant as a bounded burst and drives the FIFO's Wr_enable/data_in under full back-pressure.
- Keeps a saturating stall counter for full-induced back-pressure.
- Sits directly in front of the FIFO write side; the read side is untouched.

## Interface

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 32, word width, matches FIFO data_in
- MAX_BURST, 4, maximum beats per grant (1..16)

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; low clears all state immediately
- req_valid  in  NUM_REQ  per-requester word valid
- req_data  in  NUM_REQ*DATA_W  packed words, requester i at [i*DATA_W +: DATA_W]
- req_last  in  NUM_REQ  marks final word of requester's burst
- req_ready  out  NUM_REQ  per-requester accept, at most one bit high
- full  in  1  FIFO full flag
- Wr_enable  out  1  FIFO write strobe
- data_in  out  DATA_W  FIFO write data
- grant_id  out  $clog2(NUM_REQ)  current/last granted requester
- busy  out  1  high while in ARB_BURST
- stall_cycles  out  16  saturating count of full-stalled cycles

## Operation

- FSM: ARB_IDLE, ARB_BURST.
- ARB_IDLE:
  - If any req_valid, pick the first valid index searching from last_grant+1 upward, wrapping modulo NUM_REQ.
  - Register the pick into grant_id, clear beat_cnt, go to ARB_BURST.
  - Otherwise hold.
- ARB_BURST, with g = grant_id:
  - req_ready[g] = !full; all other req_ready bits 0.
  - Wr_enable = req_valid[g] && !full (combinational).
  - data_in = req_data[g] (combinational mux, driven whenever busy; 0 in ARB_IDLE).
  - A transfer is Wr_enable high; each transfer increments beat_cnt.
  - Burst ends (next state ARB_IDLE, last_grant <= g) on the first of:
    - a transfer with req_last[g];
    - a transfer bringing beat_cnt to MAX_BURST;
    - req_valid[g] low for a cycle.
  - full high with req_valid[g] high: no transfer, beat_cnt holds, no timeout; stall_cycles += 1, saturating at 0xFFFF.
- Wr_enable is never high while full is high.
- Requesters may change req_data only after a transfer; the arbiter does not check this.

## Timing

- Reset (low): state ARB_IDLE, last_grant = NUM_REQ-1 (requester 0 has first priority), beat_cnt 0, grant_id 0, stall_cycles 0.
- Reset outputs: busy 0, req_ready 0, Wr_enable 0, data_in 0.
- Arbitration latency: request seen in ARB_IDLE at edge N → busy and grant_id valid after edge N+1 → first write possible in cycle N+1.
- One ARB_IDLE bubble cycle between consecutive bursts, even when requests are pending.
- Zero-latency data path: the FIFO samples Wr_enable/data_in on the same edge that the requester sees req_ready && req_valid.
- full rising mid-burst: write suppressed in that same cycle; resumes the first cycle full is low.
- Fairness: a continuously requesting requester waits at most (NUM_REQ-1)*(MAX_BURST+1) cycles plus full-stall cycles.
- Reset asserted mid-burst:
  - Outputs drop to reset values asynchronously.
  - A partially written burst is not rolled back.
  - After reset release, requester 0 wins first.

## Structure

- Package fifo_arb_pkg holds:
  - typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_e;
  - default localparams for NUM_REQ, DATA_W, MAX_BURST;
  - STALL_MAX = 16'hFFFF.
- Sub-module rr_pick: combinational round-robin priority picker.
  - Inputs: req vector, last index.
  - Outputs: grant index, any_req.
- Top holds the FSM, beat counter, stall counter and output muxing.

## Test plan

- Reset release, req_valid=4'b0000 for 5 cycles → busy 0, Wr_enable 0, req_ready 0000, stall_cycles 0.
- req_valid=4'b1111 held, req_last never set, full=0, MAX_BURST=4 → grants in order 0,1,2,3,0. Each burst is 4 Wr_enable pulses followed by 1 idle cycle; data_in matches the granted requester each beat.
- Requester 2 alone sends 2 words (2nd with req_last) → exactly 2 writes with grant_id=2, then ARB_IDLE. Next requester 1 request is granted after one idle cycle.
- full=1 for 3 cycles mid-burst of requester 1 → Wr_enable 0 and req_ready[1] 0 for those 3 cycles, stall_cycles +3, beat_cnt unchanged. The burst completes its remaining beats after full drops.
- Hold full=1 with a valid grant for 70000 cycles → stall_cycles saturates at 0xFFFF, no wrap.
- Assert reset in the 2nd beat of a requester-3 burst → outputs 0 immediately. After release with req_valid=4'b1001, requester 0 is granted first.
